// File: rtl/mux_sel_seq_if.sv
// Bundle of the load handshake, scan controls, mux drive/return and serial output of mux_sel_seq.
// The slave side is the sequencer; the master side is the upstream producer plus the external 16:1 mux.
interface mux_sel_seq_if;
   logic        load_valid;
   logic [15:0] load_data;
   logic        load_ready;
   logic        hold;
   logic        abort;
   logic [15:0] w;
   logic [3:0]  s;
   logic        f;
   logic        ser_valid;
   logic        ser_bit;
   logic        ser_last;
   logic        aborted;
   logic [7:0]  frame_cnt;

   modport slave (
      input  load_valid, load_data, hold, abort, f,
      output load_ready, w, s, ser_valid, ser_bit, ser_last, aborted, frame_cnt
   );

   modport master (
      output load_valid, load_data, hold, abort, f,
      input  load_ready, w, s, ser_valid, ser_bit, ser_last, aborted, frame_cnt
   );
endinterface

// File: rtl/mux_sel_seq.sv
// Drives a word and a walking select into an external 16:1 mux and serialises the mux output
// as a 16-bit frame, with stall, abort and a wrapping completed-frame counter.
module mux_sel_seq #(
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic         clk,
   input  logic         rstn,
   mux_sel_seq_if.slave bus
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [3:0] FIRST_IDX = MSB_FIRST ? 4'd15 : 4'd0;
   localparam logic [3:0] LAST_IDX  = MSB_FIRST ? 4'd0  : 4'd15;

   state_t      state_q;
   logic [15:0] w_q;
   logic [3:0]  s_q;
   logic        ser_valid_q;
   logic        ser_bit_q;
   logic        ser_last_q;
   logic        aborted_q;
   logic [7:0]  frame_cnt_q;

   logic [3:0]  s_d;
   logic [7:0]  frame_cnt_d;
   logic        at_last_d;

   assign s_d         = MSB_FIRST ? (s_q - 4'd1) : (s_q + 4'd1);
   assign frame_cnt_d = frame_cnt_q + 8'd1;
   assign at_last_d   = (s_q == LAST_IDX);

   // Ready depends only on the registered state and reset, never on load_valid.
   assign bus.load_ready = (state_q == IDLE) && rstn;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= IDLE;
         w_q         <= 16'd0;
         s_q         <= 4'd0;
         ser_valid_q <= 1'b0;
         ser_bit_q   <= 1'b0;
         ser_last_q  <= 1'b0;
         aborted_q   <= 1'b0;
         frame_cnt_q <= 8'd0;
      end else begin
         ser_valid_q <= 1'b0;
         ser_last_q  <= 1'b0;
         aborted_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.load_valid) begin
                  w_q     <= bus.load_data;
                  s_q     <= FIRST_IDX;
                  state_q <= RUN;
               end
            end
            RUN: begin
               // Abort wins over hold; the select stays where the scan stopped.
               if (bus.abort) begin
                  state_q   <= IDLE;
                  aborted_q <= 1'b1;
               end else if (!bus.hold) begin
                  ser_bit_q   <= bus.f;
                  ser_valid_q <= 1'b1;
                  if (at_last_d) begin
                     ser_last_q  <= 1'b1;
                     state_q     <= IDLE;
                     frame_cnt_q <= frame_cnt_d;
                  end else begin
                     s_q <= s_d;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.w         = w_q;
   assign bus.s         = s_q;
   assign bus.ser_valid = ser_valid_q;
   assign bus.ser_bit   = ser_bit_q;
   assign bus.ser_last  = ser_last_q;
   assign bus.aborted   = aborted_q;
   assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_mux_sel_seq.sv
// Runs LSB-first and MSB-first sequencers side by side on shared stimulus and checks both
// against a frame-position reference model plus directed scenario checks.
module tb_mux_sel_seq;

   logic        clk;
   logic        rstn;
   logic        lv;
   logic [15:0] ld;
   logic        hd;
   logic        ab;

   mux_sel_seq_if if0 ();
   mux_sel_seq_if if1 ();

   assign if0.load_valid = lv;
   assign if0.load_data  = ld;
   assign if0.hold       = hd;
   assign if0.abort      = ab;
   assign if0.f          = if0.w[if0.s];
   assign if1.load_valid = lv;
   assign if1.load_data  = ld;
   assign if1.hold       = hd;
   assign if1.abort      = ab;
   assign if1.f          = if1.w[if1.s];

   mux_sel_seq #(.MSB_FIRST(1'b0)) dut0 (.clk(clk), .rstn(rstn), .bus(if0));
   mux_sel_seq #(.MSB_FIRST(1'b1)) dut1 (.clk(clk), .rstn(rstn), .bus(if1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: frame position k counts emitted bits, independent of select direction.
   bit          m_busy;
   bit          m_loaded;
   int          m_k;
   logic [15:0] m_word;
   logic [7:0]  m_cnt;
   logic        e_valid, e_last, e_abt, e_bit0, e_bit1, e_rstcyc;

   logic [15:0] col0, col1;
   int          n0, n1;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clr_col();
      col0 = 16'd0;
      col1 = 16'd0;
      n0   = 0;
      n1   = 0;
   endtask

   task automatic step();
      logic [3:0] es0, es1;
      @(posedge clk);
      e_rstcyc = 1'b0;
      e_valid  = 1'b0;
      e_last   = 1'b0;
      e_abt    = 1'b0;
      if (!rstn) begin
         m_busy = 0; m_loaded = 0; m_k = 0; m_word = 16'd0; m_cnt = 8'd0;
         e_bit0 = 1'b0; e_bit1 = 1'b0; e_rstcyc = 1'b1;
      end else if (!m_busy) begin
         if (lv) begin
            m_word = ld; m_k = 0; m_busy = 1; m_loaded = 1;
         end
      end else if (ab) begin
         m_busy = 0;
         e_abt  = 1'b1;
      end else if (!hd) begin
         e_valid = 1'b1;
         e_bit0  = m_word[m_k];
         e_bit1  = m_word[15 - m_k];
         if (m_k == 15) begin
            e_last = 1'b1;
            m_busy = 0;
            m_cnt  = m_cnt + 8'd1;
         end else begin
            m_k++;
         end
      end
      es0 = m_loaded ? 4'(m_k) : 4'd0;
      es1 = m_loaded ? 4'(15 - m_k) : 4'd0;
      #1;
      chk("d0.load_ready", if0.load_ready, rstn && !m_busy);
      chk("d0.w",          if0.w,          m_word);
      chk("d0.s",          if0.s,          es0);
      chk("d0.ser_valid",  if0.ser_valid,  e_valid);
      chk("d0.ser_last",   if0.ser_last,   e_last);
      chk("d0.aborted",    if0.aborted,    e_abt);
      chk("d0.frame_cnt",  if0.frame_cnt,  m_cnt);
      chk("d1.load_ready", if1.load_ready, rstn && !m_busy);
      chk("d1.w",          if1.w,          m_word);
      chk("d1.s",          if1.s,          es1);
      chk("d1.ser_valid",  if1.ser_valid,  e_valid);
      chk("d1.ser_last",   if1.ser_last,   e_last);
      chk("d1.aborted",    if1.aborted,    e_abt);
      chk("d1.frame_cnt",  if1.frame_cnt,  m_cnt);
      if (e_valid || e_rstcyc) begin
         chk("d0.ser_bit", if0.ser_bit, e_bit0);
         chk("d1.ser_bit", if1.ser_bit, e_bit1);
      end
      if (if0.ser_valid && n0 < 16) begin col0[n0] = if0.ser_bit; n0++; end
      if (if1.ser_valid && n1 < 16) begin col1[n1] = if1.ser_bit; n1++; end
   endtask

   task automatic cyc(input logic r, input logic v, input logic [15:0] d, input logic h, input logic a);
      rstn = r; lv = v; ld = d; hd = h; ab = a;
      step();
   endtask

   task automatic load_frame(input logic [15:0] d);
      clr_col();
      cyc(1'b1, 1'b1, d, 1'b0, 1'b0);
      lv = 1'b0;
   endtask

   task automatic wait_last(input string tag, input int bound, output int n);
      n = 0;
      lv = 1'b0; hd = 1'b0; ab = 1'b0;
      do begin
         step();
         n++;
      end while (!if0.ser_last && n < bound);
      chk(tag, if0.ser_last, 1'b1);
   endtask

   initial begin
      int n;
      int nlast;
      int last_at;
      int cycle;
      rstn = 1'b0; lv = 1'b0; ld = 16'd0; hd = 1'b0; ab = 1'b0;
      m_busy = 0; m_loaded = 0; m_k = 0; m_word = 16'd0; m_cnt = 8'd0;
      clr_col();

      // Reset with noisy inputs must still produce reset values.
      cyc(1'b0, 1'b1, 16'hBEEF, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      rstn = 1'b1;
      #1;
      chk("rst.ready_first_cycle", if0.load_ready, 1'b1);
      cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);

      // LSB-first reference frame, MSB-first sees it reversed.
      load_frame(16'hA5C3);
      wait_last("a5c3.last_seen", 20, n);
      chk("a5c3.cycles", 16'(n), 16'd16);
      chk("a5c3.bits_d0", col0, 16'hA5C3);
      chk("a5c3.bits_d1", col1, 16'hC3A5);
      chk("a5c3.frame_cnt", if0.frame_cnt, 8'd1);

      load_frame(16'h8001);
      wait_last("8001.last_seen", 20, n);
      chk("8001.bits_d1", col1, 16'h8001);
      chk("8001.bits_d0", col0, 16'h8001);

      // Hold for three edges once bit 4 has been emitted.
      load_frame(16'hFFFF);
      for (n = 1; n <= 25; n++) begin
         hd = (n >= 6 && n <= 8);
         step();
         if (if0.ser_last) break;
      end
      hd = 1'b0;
      chk("hold.run_cycles", 16'(n), 16'd19);
      chk("hold.bit_count", 16'(n0), 16'd16);
      chk("hold.bits_d0", col0, 16'hFFFF);

      // Abort together with hold at the edge that would emit bit 7.
      load_frame(16'h1234);
      for (int i = 0; i < 7; i++) step();
      cyc(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
      chk("abort.pulse", if0.aborted, 1'b1);
      chk("abort.no_last", if0.ser_last, 1'b0);
      chk("abort.frame_cnt", if0.frame_cnt, 8'd3);
      chk("abort.bits_before", 16'(n0), 16'd7);
      cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
      chk("abort.ready_next", if0.load_ready, 1'b1);
      chk("abort.pulse_once", if0.aborted, 1'b0);

      // Abort while idle is ignored and a simultaneous load is taken.
      cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
      cyc(1'b1, 1'b1, 16'h00F0, 1'b0, 1'b1);
      chk("idle_abort.accepted", if0.load_ready, 1'b0);
      wait_last("idle_abort.last_seen", 20, n);

      // Reset at bit 9 discards the frame; a later frame completes.
      load_frame(16'h5A5A);
      for (int i = 0; i < 9; i++) step();
      cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      chk("midrst.w", if0.w, 16'h0000);
      chk("midrst.frame_cnt", if0.frame_cnt, 8'd0);
      rstn = 1'b1;
      #1;
      chk("midrst.ready_after", if0.load_ready, 1'b1);
      load_frame(16'h0001);
      wait_last("0001.last_seen", 20, n);
      chk("0001.bits_d0", col0, 16'h0001);
      chk("0001.bits_d1", col1, 16'h8000);
      chk("0001.frame_cnt", if0.frame_cnt, 8'd1);

      // Randomised traffic checked by the model.
      for (int i = 0; i < 800; i++) begin
         cyc(($urandom_range(199) != 0), 1'($urandom), 16'($urandom),
             ($urandom_range(7) == 0), ($urandom_range(31) == 0));
      end

      // 256 back-to-back frames with load_valid held high.
      cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      nlast = 0;
      last_at = 0;
      cycle = 0;
      while (nlast < 256 && cycle < 256 * 17 + 40) begin
         cyc(1'b1, 1'b1, 16'($urandom), 1'b0, 1'b0);
         cycle++;
         if (if0.ser_last) begin
            if (nlast > 0) chk("b2b.gap", 16'(cycle - last_at), 16'd17);
            last_at = cycle;
            nlast++;
         end
      end
      chk("b2b.frames", 16'(nlast), 16'd256);
      chk("b2b.frame_cnt_wrap", if0.frame_cnt, 8'd0);
      chk("b2b.frame_cnt_wrap_d1", if1.frame_cnt, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
